ex_mul_sequencer: RTL and testbench
===================================

EX_MUL_SEQUENCER -- requirements
Module: ex_mul_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width in bits.
REQ-002 The block SHALL have parameter MUL_CODE, default 4'b1111, which is the ALU control code that selects multiply.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port ALU_Control_EX, input, 4 bits: ALU select code of the instruction in EX.
REQ-006 The block SHALL have port Valid_EX, input, 1 bit: EX holds a real, non-bubble instruction.
REQ-007 The block SHALL have port Flush_EX, input, 1 bit: kill the EX instruction.
REQ-008 The block SHALL have port Operand_A_EX, input, WIDTH bits: multiplicand.
REQ-009 The block SHALL have port Operand_B_EX, input, WIDTH bits: multiplier.
REQ-010 The block SHALL have port Stall_EX, output, 1 bit: hold IF/ID/EX and insert a bubble into MEM.
REQ-011 The block SHALL have port Mul_Busy_EX, output, 1 bit: multiply in progress.
REQ-012 The block SHALL have port Mul_Done_EX, output, 1 bit: one-cycle pulse; Mul_Result_EX is valid.
REQ-013 The block SHALL have port Mul_Result_EX, output, WIDTH bits: low WIDTH bits of A*B, registered.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 Request SHALL be defined as Valid_EX & (ALU_Control_EX == MUL_CODE) & ~Flush_EX.
REQ-016 In IDLE, on request, the block SHALL at the clock edge latch A into the multiplicand register, latch B into the multiplier register, clear the accumulator, load the counter with WIDTH, and go to RUN.
REQ-017 In each RUN cycle: if mult[0] is set, acc <= acc + mcand, truncated to WIDTH; then mcand <<= 1, mult >>= 1, and count decrements.
REQ-018 RUN SHALL go to DONE on the edge at which count goes from 1 to 0; without early termination RUN lasts exactly WIDTH cycles.
REQ-019 In DONE, the block SHALL pulse Mul_Done_EX, drive Mul_Result_EX with acc (already registered), and return to IDLE next cycle unconditionally; a request seen in DONE SHALL NOT start a new multiply.
REQ-020 Stall_EX SHALL equal ((IDLE & request) | RUN) & ~Flush_EX, combinationally; Stall_EX SHALL be 0 in DONE so the instruction advances at the end of DONE.
REQ-021 Mul_Busy_EX SHALL be 1 exactly in RUN.
REQ-022 Latency: request in cycle T0, RUN in T1..T_WIDTH, DONE in T_WIDTH+1; Stall_EX is high for WIDTH+1 cycles.
REQ-023 Flush_EX in any state SHALL force IDLE at the next edge, force Stall_EX and Mul_Done_EX low in that cycle, and leave Mul_Result_EX unchanged.
REQ-024 Mul_Result_EX SHALL hold its value until the next DONE.
REQ-025 Result arithmetic SHALL be modulo 2^WIDTH; the low bits are identical for signed and unsigned operands, and there is no overflow flag.
REQ-026 Non-multiply codes SHALL never cause a stall or a state change.

Reset
REQ-027 On Reset_n low (asynchronous), the block SHALL go to state IDLE, clear all registers, and drive Stall_EX=0, Mul_Busy_EX=0, Mul_Done_EX=0 and Mul_Result_EX=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no Done pulse.

Configuration
REQ-029 Macro EX_MUL_EARLY_TERM_EN, when defined, SHALL make RUN go to DONE at the edge where the next mult value is 0 or the count reaches 0, whichever comes first.
REQ-030 With EX_MUL_EARLY_TERM_EN defined, the number of RUN cycles SHALL be max(1, index of the highest set bit of B + 1); B=0 takes 1 cycle.
REQ-031 With EX_MUL_EARLY_TERM_EN undefined, RUN SHALL always last WIDTH cycles; results are identical in both builds.

Structure
REQ-032 Shared package ex_mul_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the ALU multiply code constant 4'b1111.
REQ-033 The shift-add registers (acc, mcand, mult, count) SHALL live in sub-module ex_mul_datapath; the FSM and stall logic SHALL stay in ex_mul_sequencer.

Verification
REQ-034 Macro off: A=3, B=5, code 4'b1111, Valid=1 at T0 -> Stall_EX high T0..T32, Mul_Done_EX at T33, Mul_Result_EX=15.
REQ-035 A=0xFFFFFFFF, B=0xFFFFFFFF -> Mul_Result_EX=0x00000001 at DONE.
REQ-036 Multiply with result 15 held; new multiply; Flush_EX at T10 -> IDLE at T11, Stall_EX low at T10, no Done pulse, Mul_Result_EX stays 15.
REQ-037 Reset_n low at T5 of RUN -> all outputs 0 immediately, no Done pulse; after release, code 4'b0010 -> Stall_EX never asserts.
REQ-038 Macro on: A=7, B=1 -> one RUN cycle, Done at T2, result 7; B=0 -> Done at T2, result 0.
REQ-039 Back-to-back multiplies with Valid and MUL_CODE held through DONE -> no restart in DONE; the second request starts only from IDLE.

Source files
------------

// File: rtl/ex_mul_pkg.sv
// Shared definitions for the EX-stage shift-add multiply sequencer:
// FSM state encoding and the ALU control code that selects multiply.
package ex_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] ALU_MUL_CODE = 4'b1111;

endpackage

// File: rtl/ex_mul_datapath.sv
// Shift-add multiply datapath: accumulator, shifting multiplicand and
// multiplier, iteration counter, and the held result register.
// Optional feature: define EX_MUL_EARLY_TERM_EN to end the iteration as
// soon as the remaining multiplier bits are all zero.
module ex_mul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int               CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mult;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_next;

    // Partial-product add for the current multiplier bit, wrapping modulo 2^WIDTH.
    assign acc_next = acc + (mult[0] ? mcand : '0);

`ifdef EX_MUL_EARLY_TERM_EN
    // Stop when the shifted multiplier will be zero or the count runs out.
    assign last = (count == COUNT_ONE) || (mult[WIDTH-1:1] == '0);
`else
    // Always iterate over every multiplier bit.
    assign last = (count == COUNT_ONE);
`endif

    // Load operands on a new request, then shift-add once per RUN cycle.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, as real flops do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mult  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            mcand <= a;
            mult  <= b;
            count <= COUNT_INIT;
        end else if (step) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mult  <= mult >> 1;
            count <= count - COUNT_ONE;
        end
    end

    // Capture the final sum on entry to DONE; it holds until the next DONE,
    // independent of the accumulator being cleared by a later request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (finish) begin
            result <= acc_next;
        end
    end

endmodule

// File: rtl/ex_mul_sequencer.sv
// EX-stage multi-cycle multiply sequencer: IDLE/RUN/DONE FSM that stalls
// the front of the pipe while the ex_mul_datapath iterates.
// Optional feature: EX_MUL_EARLY_TERM_EN (early termination, in the datapath).
module ex_mul_sequencer
    import ex_mul_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] MUL_CODE = ALU_MUL_CODE
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [3:0]       ALU_Control_EX,
    input  logic             Valid_EX,
    input  logic             Flush_EX,
    input  logic [WIDTH-1:0] Operand_A_EX,
    input  logic [WIDTH-1:0] Operand_B_EX,
    output logic             Stall_EX,
    output logic             Mul_Busy_EX,
    output logic             Mul_Done_EX,
    output logic [WIDTH-1:0] Mul_Result_EX
);

    state_t state;
    state_t state_next;
    logic   request;
    logic   load;
    logic   step;
    logic   finish;
    logic   last;

    // A live, unflushed multiply in EX; qualified by reset so the stall
    // output stays low while reset is asserted.
    assign request = Valid_EX & (ALU_Control_EX == MUL_CODE) & ~Flush_EX & Reset_n;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; a flush overrides everything.
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        Stall_EX    = 1'b0;
        Mul_Busy_EX = 1'b0;
        Mul_Done_EX = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (request) begin
                    load       = 1'b1;
                    Stall_EX   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Mul_Busy_EX = 1'b1;
                Stall_EX    = 1'b1;
                step        = 1'b1;
                if (last) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                Mul_Done_EX = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (Flush_EX) begin
            state_next  = IDLE;
            Stall_EX    = 1'b0;
            Mul_Done_EX = 1'b0;
            finish      = 1'b0;
        end
    end

    ex_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .load   (load),
        .step   (step),
        .finish (finish),
        .a      (Operand_A_EX),
        .b      (Operand_B_EX),
        .last   (last),
        .result (Mul_Result_EX)
    );

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Directed self-checking bench for ex_mul_sequencer (WIDTH=32). Expected
// RUN lengths adapt to EX_MUL_EARLY_TERM_EN when the bench is built with it.
module tb_ex_mul_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  ALU_Control_EX = 4'b0000;
    logic        Valid_EX = 1'b0;
    logic        Flush_EX = 1'b0;
    logic [31:0] Operand_A_EX = '0;
    logic [31:0] Operand_B_EX = '0;
    logic        Stall_EX;
    logic        Mul_Busy_EX;
    logic        Mul_Done_EX;
    logic [31:0] Mul_Result_EX;

    int total = 0;
    int bad   = 0;

    wire [2:0] flags = {Stall_EX, Mul_Busy_EX, Mul_Done_EX};

    ex_mul_sequencer #(
        .WIDTH    (32),
        .MUL_CODE (4'b1111)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .ALU_Control_EX (ALU_Control_EX),
        .Valid_EX       (Valid_EX),
        .Flush_EX       (Flush_EX),
        .Operand_A_EX   (Operand_A_EX),
        .Operand_B_EX   (Operand_B_EX),
        .Stall_EX       (Stall_EX),
        .Mul_Busy_EX    (Mul_Busy_EX),
        .Mul_Done_EX    (Mul_Done_EX),
        .Mul_Result_EX  (Mul_Result_EX)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected number of RUN cycles for multiplier b.
    function automatic int run_len(input logic [31:0] b);
        int n;
`ifdef EX_MUL_EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
`else
        n = 32;
`endif
        return n;
    endfunction

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // One complete multiply starting in the current (IDLE) cycle. Checks
    // {stall,busy,done} every cycle and the result in DONE. With hold set,
    // Valid_EX and the multiply code remain asserted throughout.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold);
        int n;
        n = run_len(b);
        Valid_EX       = 1'b1;
        ALU_Control_EX = 4'b1111;
        Operand_A_EX   = a;
        Operand_B_EX   = b;
        Flush_EX       = 1'b0;
        @(negedge Clk);
        check({tag, " t0 flags"}, 32'(flags), 32'b100);
        next_cycle();
        if (!hold) Valid_EX = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            check({tag, " run flags"}, 32'(flags), 32'b110);
            next_cycle();
        end
        @(negedge Clk);
        check({tag, " done flags"}, 32'(flags), 32'b001);
        check({tag, " result"}, Mul_Result_EX, exp);
        next_cycle();
    endtask

    initial begin
        int seen;

        // Reset state
        #12;
        check("reset flags", 32'(flags), 32'b000);
        check("reset result", Mul_Result_EX, 32'h0);
        Reset_n = 1'b1;
        next_cycle();

        // Basic multiply and result hold
        do_mul("3x5", 32'd3, 32'd5, 32'd15, 1'b0);
        @(negedge Clk);
        check("after done idle", 32'(flags), 32'b000);
        next_cycle();
        next_cycle();
        @(negedge Clk);
        check("result held", Mul_Result_EX, 32'd15);
        next_cycle();

        // Arithmetic patterns, wrap-around and signed operands
        do_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_mul("shift8", 32'h0000_1234, 32'h0000_0100, 32'h0012_3400, 1'b0);
        do_mul("wrap", 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b0);
        do_mul("overflow0", 32'h8000_0000, 32'd2, 32'h0000_0000, 1'b0);
        do_mul("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0);
        do_mul("7x1", 32'd7, 32'd1, 32'd7, 1'b0);
        do_mul("7x0", 32'd7, 32'd0, 32'd0, 1'b0);

        // Flush with a pending request in IDLE: no stall, no start
        Valid_EX = 1'b1; ALU_Control_EX = 4'b1111; Flush_EX = 1'b1;
        Operand_A_EX = 32'd9; Operand_B_EX = 32'd9;
        @(negedge Clk);
        check("idle flush flags", 32'(flags), 32'b000);
        next_cycle();
        Valid_EX = 1'b0; Flush_EX = 1'b0;
        @(negedge Clk);
        check("idle flush stays idle", 32'(flags), 32'b000);
        next_cycle();

        // Flush mid-RUN: result 15 must survive
        do_mul("3x5 again", 32'd3, 32'd5, 32'd15, 1'b0);
        Valid_EX = 1'b1; ALU_Control_EX = 4'b1111;
        Operand_A_EX = 32'd7; Operand_B_EX = 32'h8000_0009;
        next_cycle();                       // T1
        Valid_EX = 1'b0;
        repeat (9) next_cycle();            // T10
        Flush_EX = 1'b1;
        @(negedge Clk);
        check("flush T10 flags", 32'(flags), 32'b010);
        next_cycle();                       // T11
        Flush_EX = 1'b0;
        @(negedge Clk);
        check("flush T11 idle", 32'(flags), 32'b000);
        check("flush result kept", Mul_Result_EX, 32'd15);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            @(negedge Clk);
            if (Mul_Done_EX || Mul_Busy_EX) seen++;
        end
        check("flush no done later", 32'(seen), 32'd0);
        check("flush result still", Mul_Result_EX, 32'd15);
        next_cycle();

        // Back-to-back with request held through DONE
        do_mul("b2b first", 32'd2, 32'd3, 32'd6, 1'b1);
        do_mul("b2b second", 32'd4, 32'd5, 32'd20, 1'b0);

        // Reset asserted in RUN cycle T5
        Valid_EX = 1'b1; ALU_Control_EX = 4'b1111;
        Operand_A_EX = 32'd3; Operand_B_EX = 32'h8000_0005;
        next_cycle();                       // T1
        Valid_EX = 1'b0;
        repeat (4) next_cycle();            // T5
        #2;
        Reset_n = 1'b0;
        #1;
        check("reset mid-run flags", 32'(flags), 32'b000);
        check("reset mid-run result", Mul_Result_EX, 32'h0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (Mul_Done_EX || Stall_EX) seen++;
            @(posedge Clk);
        end
        check("reset no done", 32'(seen), 32'd0);
        #3;
        Reset_n = 1'b1;
        next_cycle();

        // Non-multiply code never stalls
        Valid_EX = 1'b1; ALU_Control_EX = 4'b0010;
        Operand_A_EX = 32'd3; Operand_B_EX = 32'd5;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (flags != 3'b000) seen++;
            next_cycle();
        end
        check("non-mul no stall", 32'(seen), 32'd0);
        check("non-mul result", Mul_Result_EX, 32'h0);
        Valid_EX = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
